// File: rtl/cnn_stream_sequencer_if.sv
// Bundle of the host word stream, pipeline image port, weight write port
// and frame status signals around the CNN stream sequencer.
interface cnn_stream_sequencer_if #(
  parameter int NUM_WEIGHTS = 126,
  parameter int WEIGHT_BITS = 8
);
  localparam int ADDR_W = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;

  logic [31:0]            in_data;
  logic                   in_valid;
  logic                   upstream_stall;
  logic [31:0]            dp_data;
  logic                   dp_valid;
  logic                   dp_row_last;
  logic                   dp_stall;
  logic                   wt_wr_en;
  logic [ADDR_W-1:0]      wt_wr_addr;
  logic [WEIGHT_BITS-1:0] wt_wr_data;
  logic                   frame_done;
  logic                   busy;
  logic                   cmd_err;

  // Host side: drives words and pipeline feedback, observes the sequencer.
  modport master (
    output in_data, in_valid, dp_stall, frame_done,
    input  upstream_stall, dp_data, dp_valid, dp_row_last,
           wt_wr_en, wt_wr_addr, wt_wr_data, busy, cmd_err
  );

  // Sequencer side.
  modport slave (
    input  in_data, in_valid, dp_stall, frame_done,
    output upstream_stall, dp_data, dp_valid, dp_row_last,
           wt_wr_en, wt_wr_addr, wt_wr_data, busy, cmd_err
  );
endinterface

// File: rtl/cnn_stream_sequencer.sv
// Front-end controller for the CNN pipeline: decodes host header words,
// streams kernel weights into the weight register file one field per cycle,
// passes image words to the pipeline with a last-row marker, and caps the
// number of frames in flight.
module cnn_stream_sequencer #(
  parameter int WIDTH           = 28,
  parameter int HEIGHT          = 28,
  parameter int VALUES_PER_WORD = 1,
  parameter int WEIGHT_BITS     = 8,
  parameter int NUM_WEIGHTS     = 126,
  parameter int MAX_INFLIGHT    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  cnn_stream_sequencer_if.slave bus
);
  localparam int ADDR_W  = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
  localparam int FPW     = 32 / WEIGHT_BITS;
  localparam int FCNT_W  = (FPW > 1) ? $clog2(FPW) : 1;
  localparam int WPR     = (WIDTH + VALUES_PER_WORD - 1) / VALUES_PER_WORD;
  localparam int COL_W   = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int ROW_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int INF_W   = $clog2(MAX_INFLIGHT + 1);

  localparam logic [1:0]        OP_NOP    = 2'b00;
  localparam logic [1:0]        OP_LOAD   = 2'b01;
  localparam logic [1:0]        OP_IMAGE  = 2'b10;
  localparam logic [16:0]       MAX_N     = 17'(NUM_WEIGHTS);
  localparam logic [INF_W-1:0]  INF_MAX   = INF_W'(MAX_INFLIGHT);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FPW - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WPR - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FRAME} state_t;

  state_t                 state_q, state_d;
  logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic [ADDR_W-1:0]      nlast_q, nlast_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [INF_W-1:0]       inflight_q;
  logic                   wt_en_q;
  logic [ADDR_W-1:0]      wt_addr_q;
  logic [WEIGHT_BITS-1:0] wt_data_q;
  logic                   cmd_err_q;

  logic                   stall;
  logic                   dp_valid;
  logic                   img_start;
  logic                   err;
  logic                   wt_sel;
  logic                   dec;
  logic [1:0]             op;
  logic [15:0]            hdr_n;
  logic [31:0]            shifted;
  logic [WEIGHT_BITS-1:0] field;

  assign op      = bus.in_data[31:30];
  assign hdr_n   = bus.in_data[15:0];
  assign shifted = bus.in_data >> (int'(fcnt_q) * WEIGHT_BITS);
  assign field   = shifted[WEIGHT_BITS-1:0];
  assign dec     = bus.frame_done && (inflight_q != '0);

  // Next-state, counter updates, handshake and strobes for the current state.
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    waddr_d   = waddr_q;
    nlast_d   = nlast_q;
    col_d     = col_q;
    row_d     = row_q;
    stall     = 1'b0;
    dp_valid  = 1'b0;
    img_start = 1'b0;
    err       = 1'b0;
    wt_sel    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (op == OP_IMAGE && inflight_q == INF_MAX) stall = 1'b1;
          if (op == OP_LOAD && inflight_q != '0) stall = 1'b1;
          if (!stall) begin
            case (op)
              OP_NOP: ;
              OP_LOAD: begin
                if (hdr_n == 16'd0) begin
                end else if ({1'b0, hdr_n} > MAX_N) begin
                  err = 1'b1;
                end else begin
                  state_d = ST_LOAD;
                  waddr_d = '0;
                  fcnt_d  = '0;
                  nlast_d = ADDR_W'(hdr_n - 16'd1);
                end
              end
              OP_IMAGE: begin
                state_d   = ST_FRAME;
                img_start = 1'b1;
                col_d     = '0;
                row_d     = '0;
              end
              default: err = 1'b1;
            endcase
          end
        end
      end
      ST_LOAD: begin
        if (bus.in_valid) begin
          wt_sel  = 1'b1;
          waddr_d = waddr_q + ADDR_W'(1);
          if (waddr_q == nlast_q || fcnt_q == FCNT_LAST) begin
            fcnt_d = '0;
          end else begin
            stall  = 1'b1;
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
          if (waddr_q == nlast_q) state_d = ST_IDLE;
        end
      end
      ST_FRAME: begin
        dp_valid = bus.in_valid;
        stall    = bus.dp_stall;
        if (bus.in_valid && !bus.dp_stall) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = ST_IDLE;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      waddr_q <= '0;
      nlast_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      waddr_q <= waddr_d;
      nlast_q <= nlast_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Registered weight write port and error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      wt_en_q   <= 1'b0;
      wt_addr_q <= '0;
      wt_data_q <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      wt_en_q   <= wt_sel;
      cmd_err_q <= err;
      if (wt_sel) begin
        wt_addr_q <= waddr_q;
        wt_data_q <= field;
      end
    end
  end

  // Frames accepted but not yet reported done; a simultaneous start and done cancel.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= '0;
    end else if (img_start && !dec) begin
      inflight_q <= inflight_q + INF_W'(1);
    end else if (dec && !img_start) begin
      inflight_q <= inflight_q - INF_W'(1);
    end
  end

  assign bus.upstream_stall = stall;
  assign bus.dp_data        = bus.in_data;
  assign bus.dp_valid       = dp_valid;
  assign bus.dp_row_last    = (state_q == ST_FRAME) && (row_q == ROW_LAST);
  assign bus.wt_wr_en       = wt_en_q;
  assign bus.wt_wr_addr     = wt_addr_q;
  assign bus.wt_wr_data     = wt_data_q;
  assign bus.busy           = (state_q != ST_IDLE) || (inflight_q != '0);
  assign bus.cmd_err        = cmd_err_q;
endmodule

// File: tb/tb_cnn_stream_sequencer.sv
// Self-checking bench for cnn_stream_sequencer: scoreboard queues of expected
// pipeline beats and weight writes, filled as stimulus is driven and drained
// against what a negedge monitor observes.
module tb_cnn_stream_sequencer;
  localparam int WIDTH  = 28;
  localparam int HEIGHT = 28;
  localparam int VPW    = 1;
  localparam int WB     = 8;
  localparam int NW     = 126;
  localparam int MAXI   = 2;
  localparam int ADDR_W = $clog2(NW);
  localparam int WPR    = (WIDTH + VPW - 1) / VPW;
  localparam int FRAME_WORDS    = WPR * HEIGHT;
  localparam int ROW_LAST_START = (HEIGHT - 1) * WPR;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cnn_stream_sequencer_if #(.NUM_WEIGHTS(NW), .WEIGHT_BITS(WB)) bus ();

  cnn_stream_sequencer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .VALUES_PER_WORD(VPW),
    .WEIGHT_BITS(WB), .NUM_WEIGHTS(NW), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses = 0;
  logic [32:0]        dp_exp[$];
  logic [32:0]        dp_obs[$];
  logic [ADDR_W+WB-1:0] wt_exp[$];
  logic [ADDR_W+WB-1:0] wt_obs[$];

  // Monitor: records every consumed pipeline beat, weight write and error pulse.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.dp_valid && !bus.dp_stall) dp_obs.push_back({bus.dp_row_last, bus.dp_data});
      if (bus.wt_wr_en) wt_obs.push_back({bus.wt_wr_addr, bus.wt_wr_data});
      if (bus.cmd_err) err_pulses++;
    end
  end

  // Watchdog so the run cannot hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one word and holds it until consumed; returns cycles taken.
  task automatic send_word(input logic [31:0] w, output int cyc);
    bit done;
    done = 0;
    cyc = 0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clock);
      cyc++;
      if (!bus.upstream_stall) done = 1;
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL send_word_timeout: word %h still stalled, need consumption within 64 cycles", w);
    end
  endtask

  task automatic pulse_frame_done();
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
  endtask

  // Streams image words, pushing the expected beats; optional 3-cycle pipeline stall.
  task automatic send_frame_body(input logic [31:0] first, input int count,
                                 input int stall_at, output int first_cyc);
    int cyc;
    logic [31:0] w;
    first_cyc = 0;
    for (int i = 0; i < count; i++) begin
      w = first + 32'(i);
      dp_exp.push_back({(i >= ROW_LAST_START), w});
      if (i == stall_at) begin
        bus.dp_stall = 1'b1;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          n_checks++;
          if (bus.upstream_stall !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL frame_stall_hold: upstream_stall=%b need 1", bus.upstream_stall);
          end
          step();
        end
        bus.dp_stall = 1'b0;
      end
      send_word(w, cyc);
      if (i == 0) first_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.dp_stall = 1'b0; bus.frame_done = 1'b0;
    repeat (2) step();
    @(negedge clock);
    n_checks += 8;
    if (bus.upstream_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_stall: got %b need 0", bus.upstream_stall); end
    if (bus.dp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_dp_valid: got %b need 0", bus.dp_valid); end
    if (bus.dp_row_last !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_row_last: got %b need 0", bus.dp_row_last); end
    if (bus.wt_wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_wt_en: got %b need 0", bus.wt_wr_en); end
    if (bus.wt_wr_addr !== '0) begin n_fail++; $display("[TB] FAIL rst_wt_addr: got %h need 0", bus.wt_wr_addr); end
    if (bus.wt_wr_data !== '0) begin n_fail++; $display("[TB] FAIL rst_wt_data: got %h need 0", bus.wt_wr_data); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b need 0", bus.busy); end
    if (bus.cmd_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_cmd_err: got %b need 0", bus.cmd_err); end
    step();
    reset = 1'b0;
    // frame_done with nothing in flight must not underflow
    pulse_frame_done();
    bus.in_data = 32'h4000_0000;
    bus.in_valid = 1'b1;
    @(negedge clock);
    n_checks += 2;
    if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL underflow_busy: got %b need 0", bus.busy); end
    if (bus.upstream_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL underflow_load_stall: got %b need 0", bus.upstream_stall); end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_load_weights();
    int cyc;
    logic [ADDR_W+WB-1:0] e, o;
    int bad;
    wt_obs.delete();
    for (int k = 0; k < 5; k++) wt_exp.push_back({ADDR_W'(k), WB'(k + 1)});
    send_word(32'h4000_0005, cyc);
    send_word(32'h0403_0201, cyc);
    n_checks++;
    if (cyc !== 4) begin n_fail++; $display("[TB] FAIL load_word0_cycles: got %0d need 4", cyc); end
    send_word(32'h0000_0005, cyc);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("[TB] FAIL load_word1_cycles: got %0d need 1", cyc); end
    repeat (3) step();
    n_checks++;
    if (wt_obs.size() !== wt_exp.size()) begin n_fail++; $display("[TB] FAIL load_write_count: got %0d need %0d", wt_obs.size(), wt_exp.size()); end
    bad = 0;
    while (wt_exp.size() > 0 && wt_obs.size() > 0) begin
      e = wt_exp.pop_front(); o = wt_obs.pop_front();
      if (o !== e) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL load_write_data: %0d bad writes, need 0", bad); end
    wt_exp.delete(); wt_obs.delete();
    @(negedge clock);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL load_back_idle: busy=%b need 0", bus.busy); end
    step();
  endtask

  task automatic test_frame();
    int cyc, fc, bad;
    logic [32:0] e, o;
    dp_obs.delete();
    send_word(32'h8000_0000, cyc);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("[TB] FAIL image_hdr_cycles: got %0d need 1", cyc); end
    send_frame_body(32'h1000_0000, FRAME_WORDS, 10, fc);
    n_checks++;
    if (fc !== 1) begin n_fail++; $display("[TB] FAIL first_word_latency: got %0d need 1", fc); end
    bus.in_data = 32'h0000_0000;
    bus.in_valid = 1'b1;
    @(negedge clock);
    n_checks += 2;
    if (bus.dp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_dp_valid: got %b need 0", bus.dp_valid); end
    if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL frame_inflight_busy: got %b need 1", bus.busy); end
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (dp_obs.size() !== dp_exp.size()) begin n_fail++; $display("[TB] FAIL frame_beat_count: got %0d need %0d", dp_obs.size(), dp_exp.size()); end
    bad = 0;
    while (dp_exp.size() > 0 && dp_obs.size() > 0) begin
      e = dp_exp.pop_front(); o = dp_obs.pop_front();
      if (o !== e) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL frame_beats: %0d bad beats, need 0", bad); end
    dp_exp.delete(); dp_obs.delete();
    pulse_frame_done();
    @(negedge clock);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL frame_done_busy: got %b need 0", bus.busy); end
    step();
  endtask

  task automatic test_inflight_limit();
    int cyc, fc, bad;
    logic [32:0] e, o;
    dp_obs.delete();
    for (int f = 0; f < 2; f++) begin
      send_word(32'h8000_0000, cyc);
      send_frame_body(32'h2000_0000 + 32'(f * 4096), FRAME_WORDS, -1, fc);
    end
    bus.in_data = 32'h8000_0000;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_checks++;
      if (bus.upstream_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL limit_hdr_stall: got %b need 1", bus.upstream_stall); end
      step();
    end
    bus.frame_done = 1'b1;
    @(negedge clock);
    n_checks++;
    if (bus.upstream_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL limit_stall_at_done: got %b need 1", bus.upstream_stall); end
    step();
    bus.frame_done = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.upstream_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL limit_release: got %b need 0", bus.upstream_stall); end
    step();
    bus.in_valid = 1'b0;
    send_frame_body(32'h3000_0000, FRAME_WORDS, -1, fc);
    repeat (2) step();
    n_checks++;
    if (dp_obs.size() !== dp_exp.size()) begin n_fail++; $display("[TB] FAIL limit_beat_count: got %0d need %0d", dp_obs.size(), dp_exp.size()); end
    bad = 0;
    while (dp_exp.size() > 0 && dp_obs.size() > 0) begin
      e = dp_exp.pop_front(); o = dp_obs.pop_front();
      if (o !== e) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL limit_beats: %0d bad beats, need 0", bad); end
    dp_exp.delete(); dp_obs.delete();
    pulse_frame_done();
    @(negedge clock);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL limit_one_left_busy: got %b need 1", bus.busy); end
    step();
  endtask

  task automatic test_load_while_inflight();
    int cyc, bad;
    logic [ADDR_W+WB-1:0] e, o;
    wt_obs.delete();
    bus.in_data = 32'h4000_0002;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_checks++;
      if (bus.upstream_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL loadw_inflight_stall: got %b need 1", bus.upstream_stall); end
      step();
    end
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.upstream_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL loadw_release: got %b need 0", bus.upstream_stall); end
    step();
    wt_exp.push_back({ADDR_W'(0), 8'hAA});
    wt_exp.push_back({ADDR_W'(1), 8'hBB});
    send_word(32'h0000_BBAA, cyc);
    n_checks++;
    if (cyc !== 2) begin n_fail++; $display("[TB] FAIL loadw_word_cycles: got %0d need 2", cyc); end
    repeat (3) step();
    n_checks++;
    if (wt_obs.size() !== wt_exp.size()) begin n_fail++; $display("[TB] FAIL loadw_write_count: got %0d need %0d", wt_obs.size(), wt_exp.size()); end
    bad = 0;
    while (wt_exp.size() > 0 && wt_obs.size() > 0) begin
      e = wt_exp.pop_front(); o = wt_obs.pop_front();
      if (o !== e) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL loadw_write_data: %0d bad writes, need 0", bad); end
    wt_exp.delete(); wt_obs.delete();
  endtask

  task automatic test_errors();
    int cyc, base;
    base = err_pulses;
    wt_obs.delete();
    send_word(32'hC000_0000, cyc);
    send_word(32'h4000_00C8, cyc);
    send_word(32'h4000_0000, cyc);
    send_word(32'h0000_0000, cyc);
    send_word(32'h4000_007F, cyc);
    repeat (3) step();
    n_checks += 3;
    if (err_pulses - base !== 3) begin n_fail++; $display("[TB] FAIL err_pulses: got %0d need 3", err_pulses - base); end
    if (wt_obs.size() !== 0) begin n_fail++; $display("[TB] FAIL err_no_writes: got %0d need 0", wt_obs.size()); end
    @(negedge clock);
    if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL err_stay_idle: busy=%b need 0", bus.busy); end
    step();
  endtask

  task automatic test_load_full();
    int cyc, bad, k;
    logic [31:0] w;
    logic [ADDR_W+WB-1:0] e, o;
    wt_obs.delete();
    send_word(32'h4000_007E, cyc);
    for (int j = 0; j < 32; j++) begin
      w = '0;
      for (int f = 0; f < 4; f++) begin
        k = 4 * j + f;
        if (k < NW) begin
          w = w | (32'(k + 1) << (8 * f));
          wt_exp.push_back({ADDR_W'(k), WB'(k + 1)});
        end else begin
          w = w | (32'hEE << (8 * f));
        end
      end
      send_word(w, cyc);
    end
    repeat (3) step();
    n_checks++;
    if (wt_obs.size() !== wt_exp.size()) begin n_fail++; $display("[TB] FAIL full_write_count: got %0d need %0d", wt_obs.size(), wt_exp.size()); end
    bad = 0;
    while (wt_exp.size() > 0 && wt_obs.size() > 0) begin
      e = wt_exp.pop_front(); o = wt_obs.pop_front();
      if (o !== e) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL full_write_data: %0d bad writes, need 0", bad); end
    wt_exp.delete(); wt_obs.delete();
  endtask

  task automatic test_reset_midframe();
    int cyc, fc, bad;
    logic [32:0] e, o;
    dp_obs.delete();
    pulse_frame_done();
    send_word(32'h8000_0000, cyc);
    send_frame_body(32'h5000_0000, 400, -1, fc);
    bus.in_data = 32'h5000_0190;
    bus.in_valid = 1'b1;
    reset = 1'b1;
    step();
    @(negedge clock);
    n_checks += 4;
    if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b need 0", bus.busy); end
    if (bus.dp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_dp_valid: got %b need 0", bus.dp_valid); end
    if (bus.dp_row_last !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_row_last: got %b need 0", bus.dp_row_last); end
    if (bus.wt_wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_wt_en: got %b need 0", bus.wt_wr_en); end
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    send_word(32'h8000_0000, cyc);
    send_frame_body(32'h6000_0000, FRAME_WORDS, 500, fc);
    repeat (2) step();
    n_checks++;
    if (dp_obs.size() !== dp_exp.size()) begin n_fail++; $display("[TB] FAIL midrst_beat_count: got %0d need %0d", dp_obs.size(), dp_exp.size()); end
    bad = 0;
    while (dp_exp.size() > 0 && dp_obs.size() > 0) begin
      e = dp_exp.pop_front(); o = dp_obs.pop_front();
      if (o !== e) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL midrst_beats: %0d bad beats, need 0", bad); end
    dp_exp.delete(); dp_obs.delete();
    pulse_frame_done();
    @(negedge clock);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_final_busy: got %b need 0", bus.busy); end
    step();
  endtask

  initial begin
    $display("[TB] starting cnn_stream_sequencer bench");
    test_reset();
    test_load_weights();
    test_frame();
    test_inflight_limit();
    test_load_while_inflight();
    test_errors();
    test_load_full();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
